// File: rtl/pattern_tx.sv
// pattern_tx: serial stimulus transmitter for the state-machine input interface.
// A pattern word is accepted over a valid/ready handshake and shifted out
// MSB-first on `i`, one bit per programmable bit period (baud_div+1 clocks).
// Mode lines m/n are held for the frame, `y` is sampled on the last clock of
// every bit period and high samples are counted (saturating) in hit_cnt.
// Each frame is followed by a one-bit-period GAP with i=0 before IDLE.
//
// Optional feature macro: PATTERN_TX_REPEAT_EN
//   defined   -> adds input repeat_en; a frame with repeat_en=1 on its last
//                GAP clock restarts in SHIFT from the captured pattern.
//   undefined -> no repeat_en port; behaves as if repeat_en were tied 0.
//
// Handshake: a frame is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; the requester holds in_valid (and stable
// payload) until that edge. Payload changes after the accept edge are ignored.
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [1:0]       in_mode,
  input  logic [DIV_W-1:0] baud_div,
  output logic             i,
  output logic             m,
  output logic             n,
  input  logic             y,
`ifdef PATTERN_TX_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_idx;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] hit_q;
  logic             i_q;
  logic             m_q;
  logic             n_q;
  logic             done_q;
  logic             rep;
  logic [LEN_W-1:0] len_clamp;

  // Selects one bit of a pattern word by a LEN_W-wide index.
  function automatic logic pick(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] idx);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return |(d & (one << idx));
  endfunction

`ifdef PATTERN_TX_REPEAT_EN
  assign rep = repeat_en;
`else
  assign rep = 1'b0;
`endif

  // Requested lengths beyond the word width send the whole word.
  always_comb begin
    len_clamp = in_len;
    if (in_len > LEN_W'(WIDTH)) len_clamp = LEN_W'(WIDTH);
  end

  // Frame sequencer: accept, shift bits, gap, optional restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      bit_idx <= '0;
      div_q   <= '0;
      div_cnt <= '0;
      hit_q   <= '0;
      i_q     <= 1'b0;
      m_q     <= 1'b0;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          i_q <= 1'b0;
          if (in_valid) begin
            data_q  <= in_data;
            len_q   <= len_clamp;
            div_q   <= baud_div;
            div_cnt <= baud_div;
            m_q     <= in_mode[1];
            n_q     <= in_mode[0];
            hit_q   <= '0;
            if (len_clamp == '0) begin
              // Empty frame: straight to GAP, done on the first GAP clock.
              state  <= GAP;
              done_q <= 1'b1;
              i_q    <= 1'b0;
            end else begin
              state   <= SHIFT;
              bit_idx <= len_clamp - LEN_W'(1);
              i_q     <= pick(in_data, len_clamp - LEN_W'(1));
            end
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            // Last clock of this bit period: sample y, move to next bit.
            if (y && (hit_q != HIT_MAX)) hit_q <= hit_q + CNT_W'(1);
            div_cnt <= div_q;
            if (bit_idx == '0) begin
              state  <= GAP;
              i_q    <= 1'b0;
              done_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx - LEN_W'(1);
              i_q     <= pick(data_q, bit_idx - LEN_W'(1));
            end
          end
        end
        GAP: begin
          i_q <= 1'b0;
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else if (rep) begin
            // Restart the captured frame without a handshake.
            hit_q   <= '0;
            div_cnt <= div_q;
            if (len_q == '0) begin
              state  <= GAP;
              done_q <= 1'b1;
            end else begin
              state   <= SHIFT;
              bit_idx <= len_q - LEN_W'(1);
              i_q     <= pick(data_q, len_q - LEN_W'(1));
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decode straight from state so reset clears them at once.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    state_dbg = state;
  end

  assign i       = i_q;
  assign m       = m_q;
  assign n       = n_q;
  assign done    = done_q;
  assign hit_cnt = hit_q;

endmodule
